// File: rtl/trig_cordic_pkg.sv
// ---------------------------------------------------------------------------
// trig_cordic_pkg
// Shared constants, state encoding and the arctangent table for the
// iterative sin/cos CORDIC unit.
//   - Angle constants are unsigned Q3.29 (3 integer bits, 29 fraction bits).
//   - CORDIC_K is the rotation-gain compensation in Q2.30, used as the
//     starting x so the final x/y land directly on cos/sin.
//   - atan_q29(i) returns atan(2^-i) in Q3.29 for i = 0..27.
// ---------------------------------------------------------------------------
package trig_cordic_pkg;

    localparam int ITERS_DEFAULT = 24;

    localparam logic [31:0] CORDIC_K          = 32'h26DD3B6A;
    localparam logic [31:0] HALF_PI_Q29       = 32'h3243F6A8;
    localparam logic [31:0] PI_Q29            = 32'h6487ED51;
    localparam logic [31:0] THREE_HALF_PI_Q29 = 32'h96CBE3F9;
    localparam logic [31:0] TWO_PI_Q29        = 32'hC90FDAA2;

    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP32_ONE  = 32'h3F800000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FOLD,
        ST_ITER,
        ST_PACK,
        ST_DONE
    } cordic_state_t;

    // Beyond i = 10 the cubic term of the series drops below half an LSB,
    // so the entries are simply 2^(29-i).
    function automatic logic [31:0] atan_q29(input logic [4:0] idx);
        logic [31:0] val;
        case (idx)
            5'd0:    val = 32'd421657428;
            5'd1:    val = 32'd248918915;
            5'd2:    val = 32'd131521918;
            5'd3:    val = 32'd66762579;
            5'd4:    val = 32'd33510843;
            5'd5:    val = 32'd16771758;
            5'd6:    val = 32'd8387925;
            5'd7:    val = 32'd4194219;
            5'd8:    val = 32'd2097141;
            5'd9:    val = 32'd1048575;
            5'd10:   val = 32'd524288;
            5'd11:   val = 32'd262144;
            5'd12:   val = 32'd131072;
            5'd13:   val = 32'd65536;
            5'd14:   val = 32'd32768;
            5'd15:   val = 32'd16384;
            5'd16:   val = 32'd8192;
            5'd17:   val = 32'd4096;
            5'd18:   val = 32'd2048;
            5'd19:   val = 32'd1024;
            5'd20:   val = 32'd512;
            5'd21:   val = 32'd256;
            5'd22:   val = 32'd128;
            5'd23:   val = 32'd64;
            5'd24:   val = 32'd32;
            5'd25:   val = 32'd16;
            5'd26:   val = 32'd8;
            5'd27:   val = 32'd4;
            default: val = 32'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/trig_fix2fp.sv
// ---------------------------------------------------------------------------
// trig_fix2fp
// Combinational signed Q2.30 -> FP32 converter.
// Sign-magnitude, leading-one normalise, mantissa truncated. Zero maps to
// +0.0 and any magnitude above 1.0 saturates to +/-1.0.
// Ports:
//   fix_in  : signed Q2.30 value
//   fp_out  : IEEE-754 single-precision result
// ---------------------------------------------------------------------------
module trig_fix2fp
    import trig_cordic_pkg::*;
(
    input  logic signed [31:0] fix_in,
    output logic        [31:0] fp_out
);

    logic        sign;
    logic [31:0] mag;
    logic [4:0]  lead;
    logic [31:0] norm;
    logic [7:0]  fp_exp;
    logic        unused_norm_bits;

    // Magnitude; -2.0 becomes 0x80000000, which the saturation path handles.
    always_comb begin
        sign = fix_in[31];
        mag  = sign ? unsigned'(-fix_in) : unsigned'(fix_in);
    end

    // Position of the leading one (bit 30 corresponds to 1.0).
    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 31; i++) begin
            if (mag[i]) lead = 5'(i);
        end
    end

    // Move the leading one to bit 30 so the mantissa is always norm[29:7].
    always_comb begin
        norm             = mag << (5'd30 - lead);
        fp_exp           = 8'd97 + 8'(lead);
        unused_norm_bits = ^{norm[31:30], norm[6:0]};
    end

    always_comb begin
        if (mag == 32'd0) begin
            fp_out = 32'd0;
        end else if (mag > 32'h4000_0000) begin
            fp_out = {sign, FP32_ONE[30:0]};
        end else begin
            fp_out = {sign, fp_exp, norm[29:7]};
        end
    end

endmodule

// File: rtl/trig_sincos_cordic.sv
// ---------------------------------------------------------------------------
// trig_sincos_cordic
// Iterative (one micro-rotation per clock) CORDIC producing FP32 sin and cos
// of an FP32 reduced angle. Sequence per transaction:
//   IDLE -> FOLD -> ITER x ITERS -> PACK -> DONE -> IDLE
// Ports:
//   clock, reset (async, active low)
//   io_in_valid / io_in_ready / io_in_angle  : FP32 angle, valid/ready input
//   io_out_valid / io_out_ready              : result handshake
//   io_out_sin / io_out_cos                  : FP32 results, held while DONE
// ---------------------------------------------------------------------------
module trig_sincos_cordic
    import trig_cordic_pkg::*;
#(
    parameter int ITERS = ITERS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    output logic        io_in_ready,
    input  logic [31:0] io_in_angle,
    output logic        io_out_valid,
    input  logic        io_out_ready,
    output logic [31:0] io_out_sin,
    output logic [31:0] io_out_cos
);

    localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

    cordic_state_t state, state_next;

    logic [31:0]        angle_reg;
    logic               special_reg;
    logic signed [31:0] x_reg, y_reg, z_reg;
    logic [1:0]         q_reg;
    logic [4:0]         iter_cnt;
    logic [31:0]        sin_reg, cos_reg;

    logic               in_sign;
    logic [7:0]         in_exp;
    logic [31:0]        in_mant;
    logic [31:0]        mag_q29, wrapped, folded, fold_r;
    logic [1:0]         fold_q;

    logic signed [31:0] x_shift, y_shift, atan_i;
    logic signed [31:0] sin_fix, cos_fix;
    logic [31:0]        sin_fp, cos_fp;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (io_in_valid) state_next = ST_FOLD;
            ST_FOLD: state_next = ST_ITER;
            ST_ITER: if (iter_cnt == LAST_ITER) state_next = ST_PACK;
            ST_PACK: state_next = ST_DONE;
            ST_DONE: if (io_out_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs depend on state only.
    always_comb begin
        io_in_ready  = (state == ST_IDLE);
        io_out_valid = (state == ST_DONE);
    end

    assign io_out_sin = sin_reg;
    assign io_out_cos = cos_reg;

    // FP32 -> unsigned Q3.29 with truncation. Q29 value = mant24 * 2^(exp-121),
    // so exponents below 98 (true exponent < -29) and denormals give zero.
    // Then fold into [0, 2pi) and split into quadrant plus residual.
    always_comb begin
        in_sign = angle_reg[31];
        in_exp  = angle_reg[30:23];
        in_mant = {9'd1, angle_reg[22:0]};

        if (in_exp < 8'd98)
            mag_q29 = 32'd0;
        else if (in_exp <= 8'd121)
            mag_q29 = in_mant >> (8'd121 - in_exp);
        else
            mag_q29 = in_mant << (in_exp - 8'd121);

        wrapped = in_sign ? (TWO_PI_Q29 - mag_q29) : mag_q29;
        folded  = (wrapped >= TWO_PI_Q29) ? (wrapped - TWO_PI_Q29) : wrapped;

        if (folded >= THREE_HALF_PI_Q29) begin
            fold_q = 2'd3;
            fold_r = folded - THREE_HALF_PI_Q29;
        end else if (folded >= PI_Q29) begin
            fold_q = 2'd2;
            fold_r = folded - PI_Q29;
        end else if (folded >= HALF_PI_Q29) begin
            fold_q = 2'd1;
            fold_r = folded - HALF_PI_Q29;
        end else begin
            fold_q = 2'd0;
            fold_r = folded;
        end
    end

    // Shifted operands for the current micro-rotation.
    always_comb begin
        x_shift = x_reg >>> iter_cnt;
        y_shift = y_reg >>> iter_cnt;
        atan_i  = $signed(atan_q29(iter_cnt));
    end

    // Undo the quadrant fold on the first-quadrant (cos, sin) pair.
    always_comb begin
        case (q_reg)
            2'd0:    begin sin_fix = y_reg;  cos_fix = x_reg;  end
            2'd1:    begin sin_fix = x_reg;  cos_fix = -y_reg; end
            2'd2:    begin sin_fix = -y_reg; cos_fix = -x_reg; end
            default: begin sin_fix = -x_reg; cos_fix = y_reg;  end
        endcase
    end

    trig_fix2fp u_sin_fp (
        .fix_in (sin_fix),
        .fp_out (sin_fp)
    );

    trig_fix2fp u_cos_fp (
        .fix_in (cos_fix),
        .fp_out (cos_fp)
    );

    // Datapath registers; each state owns its own updates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            angle_reg   <= 32'd0;
            special_reg <= 1'b0;
            x_reg       <= 32'sd0;
            y_reg       <= 32'sd0;
            z_reg       <= 32'sd0;
            q_reg       <= 2'd0;
            iter_cnt    <= 5'd0;
            sin_reg     <= 32'd0;
            cos_reg     <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io_in_valid) begin
                        angle_reg   <= io_in_angle;
                        special_reg <= &io_in_angle[30:23];
                    end
                end
                ST_FOLD: begin
                    x_reg    <= $signed(CORDIC_K);
                    y_reg    <= 32'sd0;
                    z_reg    <= $signed(fold_r);
                    q_reg    <= fold_q;
                    iter_cnt <= 5'd0;
                end
                ST_ITER: begin
                    // Rotate towards z = 0; z >= 0 rotates counter-clockwise.
                    if (z_reg[31]) begin
                        x_reg <= x_reg + y_shift;
                        y_reg <= y_reg - x_shift;
                        z_reg <= z_reg + atan_i;
                    end else begin
                        x_reg <= x_reg - y_shift;
                        y_reg <= y_reg + x_shift;
                        z_reg <= z_reg - atan_i;
                    end
                    iter_cnt <= iter_cnt + 5'd1;
                end
                ST_PACK: begin
                    sin_reg <= special_reg ? FP32_QNAN : sin_fp;
                    cos_reg <= special_reg ? FP32_QNAN : cos_fp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trig_sincos_cordic.sv
// ---------------------------------------------------------------------------
// tb_trig_sincos_cordic
// Directed self-checking bench for trig_sincos_cordic. Expected values are
// hand-computed reals (sin/cos of the given FP32 angle) or exact bit
// patterns; numeric results are accepted within 2^-20 absolute.
// ---------------------------------------------------------------------------
module tb_trig_sincos_cordic;

    localparam int  ITERS = 24;
    localparam int  LAT   = ITERS + 2;
    localparam real TOL   = 1.0 / 1048576.0;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_in_angle;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [31:0] io_out_sin;
    logic [31:0] io_out_cos;

    int check_count = 0;
    int pass_count  = 0;

    trig_sincos_cordic #(.ITERS(ITERS)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_angle  (io_in_angle),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_sin   (io_out_sin),
        .io_out_cos   (io_out_cos)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic real fp_to_real(input logic [31:0] b);
        real r;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        if (b[31]) r = -r;
        return r;
    endfunction

    function automatic real abs_err(input logic [31:0] got, input real want);
        real d;
        d = fp_to_real(got) - want;
        return (d < 0.0) ? -d : d;
    endfunction

    // Offer one angle, return cycles from the accept edge to io_out_valid
    // plus the result words; io_out_ready stays low so DONE is held.
    task automatic applyStimulus(input logic [31:0] ang, output int lat,
                                 output logic [31:0] s, output logic [31:0] c);
        @(negedge clock);
        io_in_angle  = ang;
        io_in_valid  = 1'b1;
        io_out_ready = 1'b0;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        lat = 0;
        while (!io_out_valid && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        s = io_out_sin;
        c = io_out_cos;
    endtask

    task automatic release_result();
        @(negedge clock);
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        io_in_valid  = 1'b0;
        io_in_angle  = 32'd0;
        io_out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check_count++;
        if (io_in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", io_in_ready);
        else pass_count++;
        check_count++;
        if (io_out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", io_out_valid);
        else pass_count++;
        check_count++;
        if (io_out_sin !== 32'h0) $display("[TB] FAIL reset_sin: got %h expected 00000000", io_out_sin);
        else pass_count++;
        check_count++;
        if (io_out_cos !== 32'h0) $display("[TB] FAIL reset_cos: got %h expected 00000000", io_out_cos);
        else pass_count++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_zero();
        int lat;
        logic [31:0] s, c;
        applyStimulus(32'h00000000, lat, s, c);
        check_count++;
        if (lat !== LAT) $display("[TB] FAIL zero_latency: got %0d expected %0d", lat, LAT);
        else pass_count++;
        check_count++;
        if (abs_err(s, 0.0) > TOL) $display("[TB] FAIL zero_sin: got %h (%f) expected 0.0", s, fp_to_real(s));
        else pass_count++;
        check_count++;
        if (abs_err(c, 1.0) > TOL) $display("[TB] FAIL zero_cos: got %h (%f) expected 1.0", c, fp_to_real(c));
        else pass_count++;
        release_result();
    endtask

    task automatic test_pi6();
        int lat;
        logic [31:0] s, c;
        applyStimulus(32'h3F060A92, lat, s, c);
        check_count++;
        if (lat !== LAT) $display("[TB] FAIL pi6_latency: got %0d expected %0d", lat, LAT);
        else pass_count++;
        check_count++;
        if (abs_err(s, 0.5) > TOL) $display("[TB] FAIL pi6_sin: got %h (%f) expected 0.5", s, fp_to_real(s));
        else pass_count++;
        check_count++;
        if (abs_err(c, 0.8660254) > TOL) $display("[TB] FAIL pi6_cos: got %h (%f) expected 0.8660254", c, fp_to_real(c));
        else pass_count++;
        release_result();
    endtask

    task automatic test_quadrant2();
        int lat;
        logic [31:0] s, c;
        applyStimulus(32'h40800000, lat, s, c);
        check_count++;
        if (abs_err(s, -0.7568025) > TOL) $display("[TB] FAIL q2_sin: got %h (%f) expected -0.7568025", s, fp_to_real(s));
        else pass_count++;
        check_count++;
        if (abs_err(c, -0.6536436) > TOL) $display("[TB] FAIL q2_cos: got %h (%f) expected -0.6536436", c, fp_to_real(c));
        else pass_count++;
        release_result();
    endtask

    task automatic test_two_pi_wrap();
        int lat;
        logic [31:0] s, c;
        applyStimulus(32'h40C90FDB, lat, s, c);
        check_count++;
        if (abs_err(s, 0.0) > TOL) $display("[TB] FAIL two_pi_sin: got %h (%f) expected 0.0", s, fp_to_real(s));
        else pass_count++;
        check_count++;
        if (abs_err(c, 1.0) > TOL) $display("[TB] FAIL two_pi_cos: got %h (%f) expected 1.0", c, fp_to_real(c));
        else pass_count++;
        release_result();
    endtask

    task automatic test_special();
        logic [31:0] angles [2];
        int lat;
        logic [31:0] s, c;
        angles[0] = 32'h7FC00000;
        angles[1] = 32'h7F800000;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(angles[k], lat, s, c);
            check_count++;
            if (lat !== LAT) $display("[TB] FAIL special%0d_latency: got %0d expected %0d", k, lat, LAT);
            else pass_count++;
            check_count++;
            if (s !== 32'h7FC00000) $display("[TB] FAIL special%0d_sin: got %h expected 7fc00000", k, s);
            else pass_count++;
            check_count++;
            if (c !== 32'h7FC00000) $display("[TB] FAIL special%0d_cos: got %h expected 7fc00000", k, c);
            else pass_count++;
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] s, c;
        logic seen_valid;
        applyStimulus(32'h3F060A92, lat, s, c);
        io_in_angle = 32'h40800000;
        io_in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1;
            check_count++;
            if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0 || io_out_sin !== s || io_out_cos !== c)
                $display("[TB] FAIL hold_cycle%0d: got valid=%b ready=%b sin=%h cos=%h expected valid=1 ready=0 sin=%h cos=%h",
                         k, io_out_valid, io_in_ready, io_out_sin, io_out_cos, s, c);
            else pass_count++;
        end
        @(negedge clock);
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        check_count++;
        if (io_in_ready !== 1'b1) $display("[TB] FAIL hold_release_ready: got %b expected 1", io_in_ready);
        else pass_count++;
        check_count++;
        if (io_out_valid !== 1'b0) $display("[TB] FAIL hold_release_valid: got %b expected 0", io_out_valid);
        else pass_count++;
        seen_valid = 1'b0;
        repeat (LAT + 3) begin
            @(posedge clock);
            #1;
            if (io_out_valid) seen_valid = 1'b1;
        end
        check_count++;
        if (seen_valid !== 1'b0) $display("[TB] FAIL hold_ignored_input: got valid pulse 1 expected 0");
        else pass_count++;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [31:0] s, c;
        logic seen_valid;
        @(negedge clock);
        io_in_angle = 32'h3F060A92;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        repeat (11) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_count++;
        if (io_out_valid !== 1'b0) $display("[TB] FAIL midreset_valid: got %b expected 0", io_out_valid);
        else pass_count++;
        check_count++;
        if (io_in_ready !== 1'b1) $display("[TB] FAIL midreset_ready: got %b expected 1", io_in_ready);
        else pass_count++;
        check_count++;
        if (io_out_sin !== 32'h0 || io_out_cos !== 32'h0)
            $display("[TB] FAIL midreset_outputs: got sin=%h cos=%h expected 00000000", io_out_sin, io_out_cos);
        else pass_count++;
        @(negedge clock);
        reset = 1'b1;
        seen_valid = 1'b0;
        repeat (LAT + 6) begin
            @(posedge clock);
            #1;
            if (io_out_valid) seen_valid = 1'b1;
        end
        check_count++;
        if (seen_valid !== 1'b0) $display("[TB] FAIL midreset_no_pulse: got valid pulse 1 expected 0");
        else pass_count++;
        applyStimulus(32'h3FC90FDB, lat, s, c);
        check_count++;
        if (lat !== LAT) $display("[TB] FAIL half_pi_latency: got %0d expected %0d", lat, LAT);
        else pass_count++;
        check_count++;
        if (abs_err(s, 1.0) > TOL) $display("[TB] FAIL half_pi_sin: got %h (%f) expected 1.0", s, fp_to_real(s));
        else pass_count++;
        check_count++;
        if (abs_err(c, 0.0) > TOL) $display("[TB] FAIL half_pi_cos: got %h (%f) expected 0.0", c, fp_to_real(c));
        else pass_count++;
        release_result();
    endtask

    initial begin
        $display("[TB] starting trig_sincos_cordic bench, ITERS=%0d", ITERS);
        test_reset();
        test_zero();
        test_pi6();
        test_quadrant2();
        test_two_pi_wrap();
        test_special();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
